seq_pattern_detector: RTL and testbench

Parametrised serial bit-pattern detector; the generalised successor to our fixed two-flip-flop `x_in`-driven state machines. It samples one serial bit per qualified clock and flags when the most recent `W` bits equal a compile-time `PATTERN`. Overlapping or non-overlapping matching is selectable, and an optional saturating match counter is available. It sits directly behind any serial source in the lab designs and drives indicators and downstream counters.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_det_hist.sv | 45 ++++
 rtl/seq_pattern_detector.sv | 82 ++++++++
 tb/tb_seq_pattern_detector.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared constants and helpers for the serial pattern detector.
//   W_MIN / W_MAX : legal range of the pattern length W
//   fill_width()  : width of a counter able to hold 0..W
//   w_legal()     : range check used for the elaboration-time guard
package seq_det_pkg;

    localparam int W_MIN = 2;
    localparam int W_MAX = 32;

    function automatic int fill_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic bit w_legal(input int w);
        return (w >= W_MIN) && (w <= W_MAX);
    endfunction

endpackage

// File: rtl/seq_det_hist.sv
// seq_det_hist
// History shift register plus saturating fill counter.
// Ports:
//   clock   in   rising-edge clock
//   reset   in   synchronous active-high reset
//   clear   in   synchronous soft clear (same effect as reset)
//   shift   in   accept bit_in this edge
//   bit_in  in   serial bit shifted in at position 0
//   restart in   on an accept, restart the fill count from 0
//   history out  last W accepted bits, bit 0 newest
//   fill    out  number of valid bits in history, saturates at W
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int W      = 4,
    parameter int FILL_W = fill_width(W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift,
    input  logic              bit_in,
    input  logic              restart,
    output logic [W-1:0]      history,
    output logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(W);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            history <= '0;
            fill    <= '0;
        end else if (shift) begin
            history <= {history[W-2:0], bit_in};
            // The history register keeps shifting after a non-overlapping
            // match; only the fill count restarts.
            if (restart)
                fill <= '0;
            else if (fill != FILL_MAX)
                fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector
// Flags when the last W accepted serial bits equal PATTERN (MSB oldest).
// Optional feature macro: SEQ_DET_COUNT_EN enables the saturating match
// counter; without it match_count is tied to zero.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset
//   x_in        in   serial data bit
//   x_valid     in   qualifies x_in this edge
//   clear       in   synchronous soft clear of history, fill and count
//   detect      out  registered one-cycle match pulse
//   history     out  last W accepted bits, bit 0 newest
//   fill        out  valid bits in history, saturates at W
//   match_count out  saturating number of matches
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int             W       = 4,
    parameter logic [W-1:0]   PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8,
    localparam int            FILL_W  = fill_width(W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              x_in,
    input  logic              x_valid,
    input  logic              clear,
    output logic              detect,
    output logic [W-1:0]      history,
    output logic [FILL_W-1:0] fill,
    output logic [CNT_W-1:0]  match_count
);

    if (!w_legal(W)) begin : g_w_check
        $error("seq_pattern_detector: W=%0d outside %0d..%0d", W, W_MIN, W_MAX);
    end

    logic [W-1:0] next_hist;
    logic         armed;
    logic         hit;

    // Armed means this accept completes a full window of W bits.
    assign next_hist = {history[W-2:0], x_in};
    assign armed     = (fill >= FILL_W'(W - 1));
    assign hit       = x_valid && armed && (next_hist == PATTERN);

    seq_det_hist #(
        .W      (W),
        .FILL_W (FILL_W)
    ) u_hist (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .shift   (x_valid),
        .bit_in  (x_in),
        .restart (hit && !OVERLAP),
        .history (history),
        .fill    (fill)
    );

    always_ff @(posedge clock) begin
        if (reset || clear)
            detect <= 1'b0;
        else
            detect <= hit;
    end

`ifdef SEQ_DET_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clock) begin
        if (reset || clear)
            match_count <= '0;
        else if (hit && (match_count != CNT_MAX))
            match_count <= match_count + 1'b1;
    end
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
module tb_seq_pattern_detector;

    localparam int W  = 4;
    localparam int FW = 3;
`ifdef SEQ_DET_COUNT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic x_in = 1'b0;
    logic x_valid = 1'b0;
    logic clear = 1'b0;

    logic          det_a, det_b;
    logic [W-1:0]  hist_a, hist_b;
    logic [FW-1:0] fill_a, fill_b;
    logic [7:0]    cnt_a;
    logic [1:0]    cnt_b;

    always #5 clock = ~clock;

    // Instance a: defaults (overlapping, 8-bit counter).
    seq_pattern_detector dut_a (
        .clock       (clock),
        .reset       (reset),
        .x_in        (x_in),
        .x_valid     (x_valid),
        .clear       (clear),
        .detect      (det_a),
        .history     (hist_a),
        .fill        (fill_a),
        .match_count (cnt_a)
    );

    // Instance b: non-overlapping, 2-bit counter.
    seq_pattern_detector #(.OVERLAP(1'b0), .CNT_W(2)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .x_in        (x_in),
        .x_valid     (x_valid),
        .clear       (clear),
        .detect      (det_b),
        .history     (hist_b),
        .fill        (fill_b),
        .match_count (cnt_b)
    );

    typedef struct packed {
        logic       det;
        logic [3:0] hist;
        logic [2:0] fill;
        logic [7:0] cnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [3:0] m_hist [2];
    int         m_fill [2];
    int         m_cnt  [2];

    int n_assert = 0;
    int n_fail   = 0;
    int step_no  = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic model(input int i, input bit ovl, input int cmax,
                         input bit r, input bit c, input bit v, input bit x,
                         output exp_t e);
        logic [3:0] nh;
        bit         hit;
        e = '0;
        if (r || c) begin
            m_hist[i] = 4'b0000;
            m_fill[i] = 0;
            m_cnt[i]  = 0;
        end else if (v) begin
            nh  = {m_hist[i][2:0], x};
            hit = (nh == 4'b1011) && (m_fill[i] + 1 >= W);
            e.det = hit;
            m_hist[i] = nh;
            if (hit && !ovl)
                m_fill[i] = 0;
            else if (m_fill[i] < W)
                m_fill[i] = m_fill[i] + 1;
            if (hit && m_cnt[i] < cmax)
                m_cnt[i] = m_cnt[i] + 1;
        end
        e.hist = m_hist[i];
        e.fill = 3'(m_fill[i]);
        e.cnt  = CE ? 8'(m_cnt[i]) : 8'd0;
    endtask

    task automatic step(input bit r, input bit c, input bit v, input bit x);
        exp_t ea, eb;
        @(negedge clock);
        reset   = r;
        clear   = c;
        x_valid = v;
        x_in    = x;
        model(0, 1'b1, 255, r, c, v, x, ea);
        q_a.push_back(ea);
        model(1, 1'b0, 3, r, c, v, x, eb);
        q_b.push_back(eb);
        @(posedge clock);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        chk("a_detect", 32'(det_a), 32'(ea.det));
        chk("a_history", 32'(hist_a), 32'(ea.hist));
        chk("a_fill", 32'(fill_a), 32'(ea.fill));
        chk("a_count", 32'(cnt_a), 32'(ea.cnt));
        chk("b_detect", 32'(det_b), 32'(eb.det));
        chk("b_history", 32'(hist_b), 32'(eb.hist));
        chk("b_fill", 32'(fill_b), 32'(eb.fill));
        chk("b_count", 32'(cnt_b), 32'(eb.cnt));
        if (det_a === 1'b1) pulses_a++;
        if (det_b === 1'b1) pulses_b++;
        step_no++;
    endtask

    // Accept the n low bits of pat, MSB first, with gap idle cycles after each.
    task automatic send(input logic [31:0] pat, input int n, input int gap);
        logic [31:0] p;
        p = pat;
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, 1'b0, 1'b1, p[i]);
            for (int g = 0; g < gap; g++)
                step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b1);
        pulses_a = 0;
        pulses_b = 0;
    endtask

    initial begin
        // Reset held two cycles with a valid bit present.
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_detect", 32'(det_a), 32'd0);
        chk("rst_history", 32'(hist_a), 32'd0);
        chk("rst_fill", 32'(fill_a), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);

        // Single match on consecutive accepts.
        send(32'b1011, 4, 0);
        chk("m1_detect", 32'(det_a), 32'd1);
        chk("m1_history", 32'(hist_a), 32'b1011);
        chk("m1_count", 32'(cnt_a), CE ? 32'd1 : 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("m1_pulse_end", 32'(det_a), 32'd0);

        // Overlap versus non-overlap stream.
        do_reset();
        send(32'b1011011, 7, 0);
        chk("ovl_pulses", 32'(pulses_a), 32'd2);
        chk("ovl_count", 32'(cnt_a), CE ? 32'd2 : 32'd0);
        chk("novl_pulses", 32'(pulses_b), 32'd1);
        chk("novl_fill", 32'(fill_b), 32'd3);

        // Gaps between accepted bits.
        do_reset();
        send(32'b1011, 4, 3);
        chk("gap_pulses", 32'(pulses_a), 32'd1);
        chk("gap_history", 32'(hist_a), 32'b1011);

        // Clear drops the bit presented with it.
        do_reset();
        send(32'b101, 3, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_detect", 32'(det_a), 32'd0);
        chk("clr_fill", 32'(fill_a), 32'd1);
        chk("clr_history", 32'(hist_a), 32'b0001);

        // Mid-pattern reset discards the partial pattern.
        do_reset();
        send(32'b101, 3, 0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        send(32'b1, 1, 0);
        chk("midrst_pulses", 32'(pulses_a), 32'd0);
        chk("midrst_fill", 32'(fill_a), 32'd1);

        // Completing bit with clear: no detect, no count.
        do_reset();
        send(32'b101, 3, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clrhit_detect", 32'(det_a), 32'd0);
        chk("clrhit_count", 32'(cnt_a), 32'd0);

        // Counter saturation on the 2-bit non-overlapping instance.
        do_reset();
        for (int k = 0; k < 5; k++)
            send(32'b1011, 4, 0);
        chk("sat_pulses", 32'(pulses_b), 32'd5);
        chk("sat_count_b", 32'(cnt_b), CE ? 32'd3 : 32'd0);
        chk("sat_count_a", 32'(cnt_a), CE ? 32'd5 : 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_hold_b", 32'(cnt_b), CE ? 32'd3 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
